// File: rtl/i_cache_pkg.sv
// ---------------------------------------------------------------------------
// i_cache_pkg
// Shared geometry, types and address-split helpers for the direct-mapped
// instruction cache (one 32-bit word per line).
// ---------------------------------------------------------------------------
package i_cache_pkg;

  localparam int INDEX_WIDTH = 8;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int NUM_LINES   = 1 << INDEX_WIDTH;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [DATA_WIDTH-1:0]  word_t;

  function automatic index_t pc_index(input addr_t pc);
    return pc[INDEX_WIDTH+1:2];
  endfunction

  function automatic tag_t pc_tag(input addr_t pc);
    return pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  endfunction

endpackage

// File: rtl/i_cache_if.sv
// ---------------------------------------------------------------------------
// i_cache_if
// Fetch-side and memory-controller-side signals of the instruction cache.
//   pc_cache/pc_flag      fetch request (PC, level valid)
//   ins_ori/ins_ori_flag  instruction return (data, one-cycle pulse)
//   jp_wrong              ROB mispredict flush
//   mc_req/mc_addr        memory read request (level, held until mc_done)
//   mc_ins/mc_done        memory read data (one-cycle done pulse)
// slave  : the cache's view
// master : the environment's view (fetch + ROB + memory controller)
// ---------------------------------------------------------------------------
interface i_cache_if;
  import i_cache_pkg::*;

  addr_t pc_cache;
  logic  pc_flag;
  word_t ins_ori;
  logic  ins_ori_flag;
  logic  jp_wrong;
  logic  mc_req;
  addr_t mc_addr;
  word_t mc_ins;
  logic  mc_done;

  modport slave (
    input  pc_cache, pc_flag, jp_wrong, mc_ins, mc_done,
    output ins_ori, ins_ori_flag, mc_req, mc_addr
  );

  modport master (
    output pc_cache, pc_flag, jp_wrong, mc_ins, mc_done,
    input  ins_ori, ins_ori_flag, mc_req, mc_addr
  );

endinterface

// File: rtl/i_cache_array.sv
// ---------------------------------------------------------------------------
// i_cache_array
// Valid/tag/data storage for the instruction cache.
//   clk, rst             clock, synchronous active-low reset (clears valids)
//   rd_index_i           combinational read index
//   rd_valid_o/tag/data  read result
//   we_i, wr_index_i,
//   wr_tag_i, wr_data_i  single write port; sets the line's valid bit
// ---------------------------------------------------------------------------
module i_cache_array
  import i_cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  index_t rd_index_i,
  output logic   rd_valid_o,
  output tag_t   rd_tag_o,
  output word_t  rd_data_o,
  input  logic   we_i,
  input  index_t wr_index_i,
  input  tag_t   wr_tag_i,
  input  word_t  wr_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  word_t                data_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/i_cache.sv
// ---------------------------------------------------------------------------
// i_cache
// Direct-mapped, read-only instruction cache between fetch and the memory
// controller. Hits return one cycle after accept; misses issue one word read
// and deliver the fill the cycle after mc_done unless flushed.
//   clk   clock
//   rst   synchronous active-low reset
//   rdy   global enable; rdy==0 freezes all state and outputs
//   bus   i_cache_if.slave (fetch request/response, flush, memory port)
//
// state       | meaning
// ICACHE_IDLE | ready to accept a fetch; hits are answered from here
// ICACHE_MISS | mc_req outstanding, waiting for mc_done to fill the line
// ---------------------------------------------------------------------------
module i_cache
  import i_cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  i_cache_if.slave   bus
);

  icache_state_e state_q;
  logic          cancel_q;
  word_t         ins_ori_q;
  logic          ins_flag_q;
  logic          mc_req_q;
  addr_t         mc_addr_q;

  logic  rd_valid;
  tag_t  rd_tag;
  word_t rd_data;
  logic  accept;
  logic  hit;
  logic  fill;

  // The response cycle itself never accepts, so a held pc_flag cannot
  // re-fetch the PC that is being answered.
  assign accept = (state_q == ICACHE_IDLE) && bus.pc_flag && !ins_flag_q && !bus.jp_wrong;
  assign hit    = rd_valid && (rd_tag == pc_tag(bus.pc_cache));
  assign fill   = rdy && (state_q == ICACHE_MISS) && bus.mc_done;

  i_cache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (pc_index(bus.pc_cache)),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill),
    .wr_index_i (pc_index(mc_addr_q)),
    .wr_tag_i   (pc_tag(mc_addr_q)),
    .wr_data_i  (bus.mc_ins)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ICACHE_IDLE;
      cancel_q   <= 1'b0;
      ins_ori_q  <= '0;
      ins_flag_q <= 1'b0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
    end else if (rdy) begin
      ins_flag_q <= 1'b0;
      case (state_q)
        ICACHE_IDLE: begin
          if (accept) begin
            if (hit) begin
              ins_ori_q  <= rd_data;
              ins_flag_q <= 1'b1;
            end else begin
              mc_addr_q <= {bus.pc_cache[ADDR_WIDTH-1:2], 2'b00};
              mc_req_q  <= 1'b1;
              state_q   <= ICACHE_MISS;
            end
          end
        end
        ICACHE_MISS: begin
          if (bus.mc_done) begin
            mc_req_q <= 1'b0;
            cancel_q <= 1'b0;
            state_q  <= ICACHE_IDLE;
            // A flush on the same edge as mc_done also suppresses delivery.
            if (!cancel_q && !bus.jp_wrong) begin
              ins_ori_q  <= bus.mc_ins;
              ins_flag_q <= 1'b1;
            end
          end else if (bus.jp_wrong) begin
            cancel_q <= 1'b1;
          end
        end
        default: state_q <= ICACHE_IDLE;
      endcase
    end
  end

  // A flush arriving in the response cycle squashes the pending pulse, which
  // covers a hit accepted on the edge before the flush.
  assign bus.ins_ori      = ins_ori_q;
  assign bus.ins_ori_flag = ins_flag_q && !bus.jp_wrong;
  assign bus.mc_req       = mc_req_q;
  assign bus.mc_addr      = mc_addr_q;

  // Byte-offset bits of the PC and fill address carry no information.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.pc_cache[1:0], mc_addr_q[1:0]};

endmodule

// File: tb/tb_i_cache.sv
module tb_i_cache;
  import i_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  i_cache_if bus_if ();

  i_cache u_dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0400: return 32'h00A0_0093;
      32'h0000_0010: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic request(input logic [31:0] pc);
    bus_if.pc_cache = pc;
    bus_if.pc_flag  = 1'b1;
  endtask

  // Pop the next expected instruction and compare it with the response.
  task automatic expect_resp(input string tag);
    logic [31:0] w;
    if (sb.size() > 0) w = sb.pop_front();
    else               w = 'x;
    check({tag, "_flag"}, {31'd0, bus_if.ins_ori_flag}, 32'd1);
    check({tag, "_data"}, bus_if.ins_ori, w);
  endtask

  // Memory controller answers the outstanding read; optional same-edge flush.
  task automatic mc_fill(input logic [31:0] a, input logic with_flush);
    bus_if.mc_ins   = mem_word(a);
    bus_if.mc_done  = 1'b1;
    bus_if.jp_wrong = with_flush;
    cyc();
    bus_if.mc_done  = 1'b0;
    bus_if.jp_wrong = 1'b0;
    #1;
  endtask

  task automatic do_miss(input string tag, input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    request(pc);
    sb.push_back(mem_word(a));
    cyc();
    check({tag, "_req"},  {31'd0, bus_if.mc_req}, 32'd1);
    check({tag, "_addr"}, bus_if.mc_addr, a);
    check({tag, "_noflag"}, {31'd0, bus_if.ins_ori_flag}, 32'd0);
    mc_fill(a, 1'b0);
    check({tag, "_req_drop"}, {31'd0, bus_if.mc_req}, 32'd0);
    expect_resp(tag);
    bus_if.pc_flag = 1'b0;
    cyc();
    check({tag, "_pulse1"}, {31'd0, bus_if.ins_ori_flag}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    bus_if.pc_cache = '0;
    bus_if.pc_flag  = 1'b0;
    bus_if.jp_wrong = 1'b0;
    bus_if.mc_ins   = '0;
    bus_if.mc_done  = 1'b0;
    repeat (2) cyc();

    // Reset values
    check("rst_ins_ori", bus_if.ins_ori, 32'd0);
    check("rst_flag",    {31'd0, bus_if.ins_ori_flag}, 32'd0);
    check("rst_mc_req",  {31'd0, bus_if.mc_req}, 32'd0);
    check("rst_mc_addr", bus_if.mc_addr, 32'd0);
    rst = 1'b1;
    cyc();

    // 1. Cold miss
    do_miss("cold", 32'h0000_0000);

    // 2. Back-to-back hits with pc_flag held: response cycle must not accept
    request(32'h0000_0000);
    sb.push_back(32'h0000_0013);
    sb.push_back(32'h0000_0013);
    cyc();
    expect_resp("hit1");
    check("hit1_no_req", {31'd0, bus_if.mc_req}, 32'd0);
    cyc();
    check("hit_no_dup", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    cyc();
    expect_resp("hit2");
    bus_if.pc_flag = 1'b0;
    cyc();
    check("hit2_pulse1", {31'd0, bus_if.ins_ori_flag}, 32'd0);

    // 3. Conflict: unaligned PC in same set, then original line misses again
    do_miss("conflict", 32'h0000_0402);
    do_miss("refetch0", 32'h0000_0000);

    // 4. Flush during MISS: fill completes but is not delivered
    request(32'h0000_0010);
    cyc();
    check("flushmiss_req", {31'd0, bus_if.mc_req}, 32'd1);
    bus_if.jp_wrong = 1'b1;
    bus_if.pc_flag  = 1'b0;
    cyc();
    bus_if.jp_wrong = 1'b0;
    cyc();
    check("flushmiss_req_held", {31'd0, bus_if.mc_req}, 32'd1);
    mc_fill(32'h0000_0010, 1'b0);
    check("flushmiss_noflag", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    check("flushmiss_req_drop", {31'd0, bus_if.mc_req}, 32'd0);
    cyc();
    check("flushmiss_noflag2", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    request(32'h0000_0010);
    sb.push_back(32'hDEAD_BEEF);
    cyc();
    expect_resp("flushmiss_hit");
    check("flushmiss_hit_noreq", {31'd0, bus_if.mc_req}, 32'd0);
    bus_if.pc_flag = 1'b0;
    cyc();

    // 4b. Flush on the same edge as mc_done
    request(32'h0000_0020);
    cyc();
    check("sameedge_req", {31'd0, bus_if.mc_req}, 32'd1);
    bus_if.pc_flag = 1'b0;
    mc_fill(32'h0000_0020, 1'b1);
    check("sameedge_noflag", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    check("sameedge_req_drop", {31'd0, bus_if.mc_req}, 32'd0);
    request(32'h0000_0020);
    sb.push_back(mem_word(32'h0000_0020));
    cyc();
    expect_resp("sameedge_hit");
    bus_if.pc_flag = 1'b0;
    cyc();

    // 5. Flush on hit: pulse squashed, new (missing) PC blocked while flushing
    request(32'h0000_0000);
    cyc();
    bus_if.jp_wrong = 1'b1;
    bus_if.pc_cache = 32'h0000_0050;
    #1;
    check("flushhit_squash", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    cyc();
    check("flushhit_blocked", {31'd0, bus_if.mc_req}, 32'd0);
    bus_if.jp_wrong = 1'b0;
    sb.push_back(mem_word(32'h0000_0050));
    cyc();
    check("flushhit_newreq", {31'd0, bus_if.mc_req}, 32'd1);
    check("flushhit_newaddr", bus_if.mc_addr, 32'h0000_0050);
    mc_fill(32'h0000_0050, 1'b0);
    expect_resp("flushhit_new");
    bus_if.pc_flag = 1'b0;
    cyc();

    // 6. rdy=0 during MISS freezes everything
    request(32'h0000_0030);
    sb.push_back(mem_word(32'h0000_0030));
    cyc();
    check("rdy_req", {31'd0, bus_if.mc_req}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rdy_frozen_req",  {31'd0, bus_if.mc_req}, 32'd1);
      check("rdy_frozen_addr", bus_if.mc_addr, 32'h0000_0030);
      check("rdy_frozen_flag", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    end
    rdy = 1'b1;
    mc_fill(32'h0000_0030, 1'b0);
    expect_resp("rdy_fill");
    bus_if.pc_flag = 1'b0;
    cyc();

    // Pulse is held while rdy=0
    request(32'h0000_0030);
    sb.push_back(mem_word(32'h0000_0030));
    cyc();
    expect_resp("rdy_hit");
    rdy = 1'b0;
    bus_if.pc_flag = 1'b0;
    cyc();
    check("rdy_hold_flag", {31'd0, bus_if.ins_ori_flag}, 32'd1);
    check("rdy_hold_data", bus_if.ins_ori, mem_word(32'h0000_0030));
    rdy = 1'b1;
    cyc();
    check("rdy_release_flag", {31'd0, bus_if.ins_ori_flag}, 32'd0);

    // Reset mid-MISS: request dropped, all lines invalidated
    request(32'h0000_0040);
    cyc();
    check("rstmiss_req", {31'd0, bus_if.mc_req}, 32'd1);
    rst = 1'b0;
    bus_if.pc_flag = 1'b0;
    cyc();
    check("rstmiss_req_drop", {31'd0, bus_if.mc_req}, 32'd0);
    check("rstmiss_addr", bus_if.mc_addr, 32'd0);
    check("rstmiss_flag", {31'd0, bus_if.ins_ori_flag}, 32'd0);
    rst = 1'b1;
    cyc();
    do_miss("post_rst", 32'h0000_0000);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
